// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control and its consumers
// (ALUControl reuses the ALUOp constants).
package mips_ctrl_pkg;

    // Control FSM states; codes 12..15 are unreachable and decode to FETCH / all-zero outputs.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp bus toward ALUControl
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore output vector, a pure function of state
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
    } ctrl_word_t;

    // True for the opcodes the FSM knows how to sequence
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/control_word_decode.sv
// State -> Moore control word. Anything not listed for a state stays 0,
// and corrupt state codes produce an all-zero word.
module control_word_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t cw
);

    // Per-state control word, zero default first
    always_comb begin
        cw = '0;
        case (state)
            FETCH: begin
                cw.ir_write  = 1'b1;
                cw.pc_write  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
            end
            DECODE: begin
                // branch target precompute into ALUOut
                cw.alu_src_b = SRCB_IMM_SH2;
            end
            MEMADR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                cw.iord = 1'b1;
            end
            MEMWB: begin
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
            end
            MEMWR: begin
                cw.iord      = 1'b1;
                cw.mem_write = 1'b1;
            end
            EXECUTE: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG;
                cw.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                cw.reg_dst   = 1'b1;
                cw.reg_write = 1'b1;
            end
            BRANCH: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALUOP_SUB;
                cw.pc_src    = PCSRC_ALUOUT;
                cw.branch    = 1'b1;
            end
            ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                cw.reg_write = 1'b1;
            end
            JUMP: begin
                cw.pc_src   = PCSRC_JUMP;
                cw.pc_write = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control: state register, next-state logic, and the
// two input-dependent terms (PCEn, IllegalOp). Moore outputs come from
// control_word_decode.
module multicycle_main_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic [1:0] PCSrc,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       IllegalOp
);

    state_t     state, state_next;
    ctrl_word_t cw;

    // State register; async reset abandons any in-flight instruction at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state; Op only matters in DECODE and MEMADR
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;  // illegal: NOP
                endcase
            end
            MEMADR: begin
                if (Op == OP_LW)      state_next = MEMRD;
                else if (Op == OP_SW) state_next = MEMWR;
                else                  state_next = FETCH;
            end
            MEMRD:   state_next = MEMWB;
            EXECUTE: state_next = ALUWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;  // writebacks, BRANCH, JUMP, corrupt codes
        endcase
    end

    control_word_decode u_decode (
        .state (state),
        .cw    (cw)
    );

    assign ALUOp     = cw.alu_op;
    assign ALUSrcA   = cw.alu_src_a;
    assign ALUSrcB   = cw.alu_src_b;
    assign IorD      = cw.iord;
    assign PCSrc     = cw.pc_src;
    assign RegDst    = cw.reg_dst;
    assign MemtoReg  = cw.mem_to_reg;
    assign IRWrite   = cw.ir_write;
    assign MemWrite  = cw.mem_write;
    assign RegWrite  = cw.reg_write;
    assign PCWrite   = cw.pc_write;
    assign Branch    = cw.branch;

    // Branch resolves on the live Zero flag in the same cycle
    assign PCEn      = cw.pc_write | (cw.branch & Zero);
    assign IllegalOp = (state == DECODE) && !op_supported(Op);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized bench for multicycle_main_control. The reference model is a
// per-opcode list of step names, each with its documented output values.
module tb_multicycle_main_control;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Op = 6'b0;
    logic       Zero = 1'b0;
    logic [1:0] ALUOp, ALUSrcB, PCSrc;
    logic       ALUSrcA, IorD, RegDst, MemtoReg, IRWrite, MemWrite;
    logic       RegWrite, PCWrite, Branch, PCEn, IllegalOp;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_main_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCEn(PCEn), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    wire [16:0] dut_vec = {ALUOp, ALUSrcA, ALUSrcB, IorD, PCSrc, RegDst, MemtoReg,
                           IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn, IllegalOp};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op == T_R || op == T_LW || op == T_SW || op == T_BEQ ||
               op == T_ADDI || op == T_J;
    endfunction

    // Step names an instruction walks through, from its FETCH cycle
    function automatic string step_at(input logic [5:0] op, input int i);
        string s[$];
        if (i == 0) return "F";
        if (i == 1) return "D";
        case (op)
            T_LW:    s = '{"MA", "MR", "MWB"};
            T_SW:    s = '{"MA", "MW"};
            T_R:     s = '{"EX", "AWB"};
            T_ADDI:  s = '{"AEX", "AW2"};
            T_BEQ:   s = '{"BR"};
            T_J:     s = '{"J"};
            default: s = '{};
        endcase
        if (i - 2 < s.size()) return s[i-2];
        return "";
    endfunction

    // Documented outputs of each step
    function automatic logic [16:0] expect_vec(input string step, input logic [5:0] op, input logic z);
        logic [1:0] aluop = 2'b00, srcb = 2'b00, pcsrc = 2'b00;
        logic srca = 0, iord = 0, regdst = 0, m2r = 0, irw = 0, mw = 0;
        logic rw = 0, pcw = 0, br = 0, ill = 0;
        case (step)
            "F":   begin irw = 1; pcw = 1; srcb = 2'b01; end
            "D":   begin srcb = 2'b11; ill = !legal(op); end
            "MA":  begin srca = 1; srcb = 2'b10; end
            "MR":  iord = 1;
            "MWB": begin m2r = 1; rw = 1; end
            "MW":  begin iord = 1; mw = 1; end
            "EX":  begin srca = 1; srcb = 2'b00; aluop = 2'b10; end
            "AWB": begin regdst = 1; rw = 1; end
            "BR":  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; br = 1; end
            "AEX": begin srca = 1; srcb = 2'b10; end
            "AW2": rw = 1;
            "J":   begin pcsrc = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {aluop, srca, srcb, iord, pcsrc, regdst, m2r, irw, mw, rw, pcw, br,
                pcw | (br & z), ill};
    endfunction

    // Runs one instruction starting in FETCH (called before the FETCH edge).
    // Op is scrambled in steps that must ignore it. If rst_step matches a
    // step, reset pulses mid-cycle there and the instruction is abandoned.
    task automatic run_instr(input logic [5:0] op, input logic z, input int rst_step);
        string st;
        for (int i = 0; i < 8; i++) begin
            st = step_at(op, i);
            if (st == "") return;
            Op   = (st == "D" || st == "MA") ? op : 6'($urandom);
            Zero = (st == "BR") ? z : 1'($urandom);
            #2;
            chk({"out_", st}, 32'(dut_vec), 32'(expect_vec(st, op, Zero)));
            chk("aluop_not_11", 32'(ALUOp == 2'b11), 32'd0);
            if (i == rst_step) begin
                #1 reset = 1'b1;
                #1;
                chk({"rst_in_", st}, 32'(dut_vec), 32'(expect_vec("F", op, Zero)));
                chk("rst_memwrite", 32'(MemWrite), 32'd0);
                #2 reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] op;
        int         rs;

        // Async reset with no clock edge
        #3 reset = 1'b1;
        #1 chk("reset_async", 32'(dut_vec), 32'(expect_vec("F", 6'd0, Zero)));
        #8 reset = 1'b0;
        #1 chk("reset_hold_fetch", 32'(dut_vec), 32'(expect_vec("F", 6'd0, Zero)));
        @(posedge clk);
        #1 Op = T_LW;
        #2 chk("first_edge_decode", 32'(dut_vec), 32'(expect_vec("D", T_LW, Zero)));
        #1 reset = 1'b1;
        #1 reset = 1'b0;

        // Directed walk through every path
        run_instr(T_LW,   1'b0, -1);
        run_instr(T_R,    1'b0, -1);
        run_instr(T_ADDI, 1'b0, -1);
        run_instr(T_BEQ,  1'b1, -1);
        run_instr(T_BEQ,  1'b0, -1);
        run_instr(T_J,    1'b0, -1);
        run_instr(6'b111111, 1'b0, -1);
        run_instr(T_SW,   1'b0, 3);   // reset during MEMWR
        run_instr(T_R,    1'b0, -1);
        run_instr(T_LW,   1'b0, 4);   // reset during MEMWB

        // Random instruction stream with occasional reset
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0: op = T_LW;
                1: op = T_SW;
                2: op = T_R;
                3: op = T_BEQ;
                4: op = T_ADDI;
                5: op = T_J;
                default: begin
                    op = 6'($urandom);
                    while (legal(op)) op = 6'($urandom);
                end
            endcase
            rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, 1'($urandom), rs);
        end

        // Last instruction must have returned to FETCH
        Op = 6'($urandom);
        #2 chk("final_fetch", 32'(dut_vec), 32'(expect_vec("F", Op, Zero)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Multicycle MIPS main-control FSM. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and muxes. It is the producer side of the 2-bit `ALUOp` bus consumed by the `ALUControl` decoder, and it sits between the instruction register's opcode field and the multicycle datapath.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- `clk` in 1: single clock; state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces state to FETCH.
- `Op` in 6: opcode, `instr[31:26]`, from the instruction register.
- `Zero` in 1: ALU zero flag.
- `ALUOp` out 2: 00 add, 01 subtract, 10 decode Funct. 11 is never driven.
- `ALUSrcA` out 1: 0 selects PC, 1 selects register A.
- `ALUSrcB` out 2: 00 B, 01 constant 4, 10 SignImm, 11 SignImm<<2.
- `IorD` out 1: memory address from PC (0) or ALUOut (1).
- `PCSrc` out 2: 00 ALUResult, 01 ALUOut, 10 jump target.
- `RegDst`, `MemtoReg` out 1 each: register-file write mux selects.
- `IRWrite`, `MemWrite`, `RegWrite`, `PCWrite`, `Branch` out 1 each: enables.
- `PCEn` out 1: equals `PCWrite | (Branch & Zero)`.
- `IllegalOp` out 1: asserted in DECODE when `Op` is unsupported.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- Moore outputs are decoded from state alone; `PCEn` and `IllegalOp` are the only combinational-input terms. Any output not listed for a state is 0, and `ALUOp` defaults to 00.
- FETCH: `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=01. Next state is DECODE.
- DECODE: `ALUSrcB`=11 (branch target precompute). Next state by opcode:
  - lw or sw goes to MEMADR.
  - R-type goes to EXECUTE.
  - beq goes to BRANCH.
  - addi goes to ADDIEX.
  - j goes to JUMP.
  - Any other opcode goes to FETCH with `IllegalOp`=1 for that cycle (the instruction is treated as a NOP).
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `IorD`=1. Next is MEMWB.
- MEMWB: `MemtoReg`=1, `RegWrite`=1. Next is FETCH.
- MEMWR: `IorD`=1, `MemWrite`=1. Next is FETCH.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next is ALUWB.
- ALUWB: `RegDst`=1, `RegWrite`=1. Next is FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp`=01, `PCSrc`=01, `Branch`=1. Next is FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10. Next is ADDIWB.
- ADDIWB: `RegWrite`=1. Next is FETCH.
- JUMP: `PCSrc`=10, `PCWrite`=1. Next is FETCH.
- `Op` is sampled only in DECODE and MEMADR. Changes to `Op` in other states have no effect.
- The state register uses a 4-bit encoding. An unreachable or corrupt encoding returns to FETCH on the next edge and all outputs read 0 while in it.

## Timing
- Cycles per instruction, counted from entry into FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Reset is asynchronous: state goes to FETCH immediately, without waiting for a clock edge.
  - Outputs then show FETCH values: `IRWrite`=1, `PCWrite`=1, `PCEn`=1, `ALUSrcB`=01, all others 0.
  - The datapath is held in reset concurrently, so these enables have no effect.
- Reset mid-instruction abandons the instruction. In particular, a MEMWR or MEMWB cycle interrupted by reset must not complete its write after reset deasserts.
- After reset deasserts, the first rising edge moves FETCH to DECODE.
- `PCEn` in BRANCH follows `Zero` combinationally within the same cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (FETCH…JUMP, 4 bits);
  - opcode constants;
  - `ALUOp` constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), shared with ALUControl;
  - `ALUSrcB` and `PCSrc` select constants.
- One sub-module is natural: `control_word_decode`, a pure function from state to the Moore output vector. The top level keeps the state register, next-state logic, `PCEn` and `IllegalOp`.

## Test plan
- **Reset:** assert `reset` mid-clock, with no edge. Required: state is FETCH and outputs show FETCH values without waiting for an edge. Deassert, apply one edge: state is DECODE.
- **lw:** `Op`=100011. Required state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `ALUOp`=00 throughout; `RegWrite`=1 and `MemtoReg`=1 only in MEMWB.
- **R-type then addi:** `Op`=000000. Required: `ALUOp`=10 and `ALUSrcB`=00 in EXECUTE, `RegDst`=1 in ALUWB, 4 cycles total. Then `Op`=001000: 4 cycles, `ALUSrcB`=10 in ADDIEX.
- **beq:** `Op`=000100 run twice. With `Zero`=1: `PCEn`=1 in BRANCH. With `Zero`=0: `PCEn`=0. Both cases: `ALUOp`=01, 3 cycles.
- **j and illegal opcode:** `Op`=000010 gives `PCSrc`=10 and `PCEn`=1 in JUMP. `Op`=111111 gives `IllegalOp`=1 in DECODE only, then FETCH. `ALUOp`=11 is never observed in any run.
- **sw with reset:** `Op`=101011. Assert `reset` during MEMWR. Required: `MemWrite` drops to 0 immediately, and the next instruction starts from FETCH.
